// File: rtl/cpu_seq_if.sv
// Bus bundle between the instruction sequencer and its ROM / data-memory environment.
// Defining SEQ_SINGLE_STEP_EN adds the step_mode/step debug controls.
interface cpu_seq_if;
    logic        start;
    logic        stop;
    logic [11:0] instr;
    logic [4:0]  rdata1;
    logic [4:0]  rdata2;
    logic [2:0]  pc;
    logic [2:0]  opcode;
    logic [2:0]  rloc1;
    logic [2:0]  rloc2;
    logic [2:0]  wloc;
    logic [4:0]  op1;
    logic [4:0]  op2;
    logic        mem_we;
    logic        busy;
    logic        halted;
    logic [7:0]  retired;
`ifdef SEQ_SINGLE_STEP_EN
    logic        step_mode;
    logic        step;
`endif

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        output step_mode, step,
`endif
        output start, stop, instr, rdata1, rdata2,
        input  pc, opcode, rloc1, rloc2, wloc, op1, op2, mem_we, busy, halted, retired
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        input  step_mode, step,
`endif
        input  start, stop, instr, rdata1, rdata2,
        output pc, opcode, rloc1, rloc2, wloc, op1, op2, mem_we, busy, halted, retired
    );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Four-phase fetch/decode/execute/writeback sequencer for a tiny 8-word-program CPU.
// Defining SEQ_SINGLE_STEP_EN adds a PAUSE state entered after each instruction in step mode.
module cpu_seq_ctrl (
    input  logic     clk,
    input  logic     rst_n,
    cpu_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE     = 3'd6,
`endif
        S_HALT      = 3'd5
    } state_t;

    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_HALT   = 3'd7;

    state_t      state;
    state_t      state_next;
    logic [2:0]  pc;
    logic [11:0] ir;
    logic [4:0]  op1;
    logic [4:0]  op2;
    logic [7:0]  retired;

    logic        is_branch;
    logic        is_halt;
    logic [2:0]  pc_adv;

    assign is_branch = (ir[11:9] == OP_BRANCH);
    assign is_halt   = (ir[11:9] == OP_HALT);
    // Branch is taken when the first operand is zero; target comes from op2's upper bits.
    assign pc_adv    = (is_branch && (op1 == 5'd0)) ? op2[4:2] : pc + 3'd1;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (bus.start) state_next = S_FETCH;
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = S_EXECUTE;
            S_EXECUTE:   state_next = S_WRITEBACK;
            S_WRITEBACK: begin
                if (is_halt) begin
                    state_next = S_HALT;
                end else if (bus.stop) begin
                    state_next = S_IDLE;
`ifdef SEQ_SINGLE_STEP_EN
                end else if (bus.step_mode) begin
                    state_next = S_PAUSE;
`endif
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_HALT:      if (bus.start) state_next = S_FETCH;
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
                if (bus.stop) begin
                    state_next = S_IDLE;
                end else if (bus.step) begin
                    state_next = S_FETCH;
                end
            end
`endif
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= 3'd0;
            ir      <= 12'd0;
            op1     <= 5'd0;
            op2     <= 5'd0;
            retired <= 8'd0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        pc      <= 3'd0;
                        retired <= 8'd0;
                    end
                end
                S_FETCH:   ir <= bus.instr;
                S_EXECUTE: begin
                    op1 <= bus.rdata1;
                    op2 <= bus.rdata2;
                end
                S_WRITEBACK: begin
                    retired <= retired + 8'd1;
                    if (!is_halt) pc <= pc_adv;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the registered state, so reset kills them at once.
    always_comb begin
        bus.mem_we = 1'b0;
        bus.busy   = 1'b1;
        bus.halted = 1'b0;
        case (state)
            S_IDLE:      bus.busy = 1'b0;
            S_HALT: begin
                bus.busy   = 1'b0;
                bus.halted = 1'b1;
            end
            S_WRITEBACK: bus.mem_we = !is_branch && !is_halt;
            default: ;
        endcase
    end

    assign bus.pc      = pc;
    assign bus.opcode  = ir[11:9];
    assign bus.rloc1   = ir[8:6];
    assign bus.rloc2   = ir[5:3];
    assign bus.wloc    = ir[2:0];
    assign bus.op1     = op1;
    assign bus.op2     = op2;
    assign bus.retired = retired;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: stimulus queues expected writes/retirements, a monitor checks them.
// Build with SEQ_SINGLE_STEP_EN to also exercise single-step pausing.
module tb_cpu_seq_ctrl;

    typedef struct {
        logic [2:0] pc;
        logic [2:0] wloc;
        logic [4:0] op1;
        logic [4:0] op2;
    } wr_t;

    typedef struct {
        logic [2:0] pc;
        logic [7:0] retired;
        logic       busy;
        logic       halted;
    } ret_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [11:0] rom  [8];
    logic [4:0]  dmem [8];
    wr_t         wr_q [$];
    ret_t        ret_q[$];
    logic [7:0]  prev_ret = 8'd0;

    cpu_seq_if bus();

    cpu_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr  = rom[bus.pc];
    assign bus.rdata1 = dmem[bus.rloc1];
    assign bus.rdata2 = dmem[bus.rloc2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.pc, bus.opcode, bus.rloc1, bus.rloc2, bus.wloc, bus.op1, bus.op2,
                    bus.mem_we, bus.busy, bus.halted, bus.retired});
    endfunction

    task automatic advance(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_halted(input int max_cycles);
        int n = 0;
        while (!bus.halted && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", bus.halted, 1'b1);
    endtask

    task automatic exp_wr(input logic [2:0] pc, input logic [2:0] wloc,
                          input logic [4:0] op1, input logic [4:0] op2);
        wr_q.push_back('{pc: pc, wloc: wloc, op1: op1, op2: op2});
    endtask

    task automatic exp_ret(input logic [2:0] pc, input logic [7:0] retired,
                           input logic busy, input logic halted);
        ret_q.push_back('{pc: pc, retired: retired, busy: busy, halted: halted});
    endtask

    // Monitor: every write strobe and every retirement must match the head of its queue.
    always @(negedge clk) begin
        wr_t  w;
        ret_t r;
        if (!rst_n) begin
            prev_ret = 8'd0;
        end else begin
            if (bus.mem_we) begin
                if (wr_q.size() == 0) begin
                    check("mem_we_spurious", bus.mem_we, 1'b0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_pc",   bus.pc,   w.pc);
                    check("wr_wloc", bus.wloc, w.wloc);
                    check("wr_op1",  bus.op1,  w.op1);
                    check("wr_op2",  bus.op2,  w.op2);
                end
            end
            if (bus.retired == prev_ret + 8'd1) begin
                if (ret_q.size() == 0) begin
                    check("retire_spurious", bus.retired, prev_ret);
                end else begin
                    r = ret_q.pop_front();
                    check("ret_pc",      bus.pc,      r.pc);
                    check("ret_count",   bus.retired, r.retired);
                    check("ret_busy",    bus.busy,    r.busy);
                    check("ret_halted",  bus.halted,  r.halted);
                end
            end
            prev_ret = bus.retired;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            rom[i]  = 12'h000;
            dmem[i] = 5'd0;
        end
        dmem[1] = 5'd3;
        dmem[2] = 5'b10100;
        dmem[3] = 5'd7;
        dmem[4] = 5'd16;

        // Reset state
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        advance(2);
        rst_n = 1'b1;
        advance(2);
        check("idle_after_reset", {bus.busy, bus.halted, bus.mem_we}, 3'b000);

        // Run 1: not-taken branch, write, taken branch to 4, halt at 4.
        rom[0] = 12'h240;  // opcode 1, op1 = 3 -> falls through, no write
        rom[1] = 12'h440;  // opcode 2, write wloc 0
        rom[2] = 12'h220;  // opcode 1, op1 = 0, op2 = 16 -> pc 4
        rom[4] = 12'hE00;  // halt
        exp_ret(3'd1, 8'd1, 1'b1, 1'b0);
        exp_wr (3'd1, 3'd0, 5'd3, 5'd0);
        exp_ret(3'd2, 8'd2, 1'b1, 1'b0);
        exp_ret(3'd4, 8'd3, 1'b1, 1'b0);
        exp_ret(3'd4, 8'd4, 1'b0, 1'b1);
        pulse_start();
        check("run1_first_fetch", {bus.pc, bus.retired, bus.busy}, {3'd0, 8'd0, 1'b1});
        wait_halted(40);
        advance(4);
        check("halt_stable", {bus.pc, bus.retired, bus.busy, bus.halted}, {3'd4, 8'd4, 1'b0, 1'b1});

        // Run 2: restart from HALT; taken branch to 5, writes through 7, wrap, stop in DECODE.
        rom[0] = 12'h210;  // opcode 1, op1 = 0, op2 = 5'b10100 -> pc 5
        rom[5] = 12'h6CD;
        rom[6] = 12'h087;
        rom[7] = 12'h011;
        exp_ret(3'd5, 8'd1, 1'b1, 1'b0);
        exp_wr (3'd5, 3'd5, 5'd7, 5'd3);
        exp_ret(3'd6, 8'd2, 1'b1, 1'b0);
        exp_wr (3'd6, 3'd7, 5'd20, 5'd0);
        exp_ret(3'd7, 8'd3, 1'b1, 1'b0);
        exp_wr (3'd7, 3'd1, 5'd0, 5'd20);
        exp_ret(3'd0, 8'd4, 1'b0, 1'b0);
        pulse_start();
        check("restart_clears", {bus.pc, bus.retired, bus.busy, bus.halted}, {3'd0, 8'd0, 1'b1, 1'b0});
        advance(5);
        bus.start = 1'b1;  // ignored while busy
        advance(1);
        bus.start = 1'b0;
        advance(7);
        bus.stop = 1'b1;   // instruction at pc 7 is in DECODE
        advance(3);
        bus.stop = 1'b0;
        advance(4);
        check("idle_after_stop", {bus.pc, bus.retired, bus.busy, bus.halted}, {3'd0, 8'd4, 1'b0, 1'b0});

        // Run 3: asynchronous reset during the second instruction's EXECUTE.
        rom[0] = 12'h440;
        rom[1] = 12'h6CD;
        exp_wr (3'd0, 3'd0, 5'd3, 5'd0);
        exp_ret(3'd1, 8'd1, 1'b1, 1'b0);
        pulse_start();
        advance(6);
        check("pre_reset_ir", {bus.opcode, bus.op1}, {3'd3, 5'd3});
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", all_outs(), 64'd0);
        advance(2);
        rst_n = 1'b1;
        advance(10);
        check("post_reset_idle", {bus.busy, bus.retired}, {1'b0, 8'd0});

`ifdef SEQ_SINGLE_STEP_EN
        // Run 4: step mode pauses after each instruction; one step retires one more.
        rom[0] = 12'h440;
        rom[1] = 12'h440;
        rom[2] = 12'hE00;
        bus.step_mode = 1'b1;
        exp_wr (3'd0, 3'd0, 5'd3, 5'd0);
        exp_ret(3'd1, 8'd1, 1'b1, 1'b0);
        exp_wr (3'd1, 3'd0, 5'd3, 5'd0);
        exp_ret(3'd2, 8'd2, 1'b1, 1'b0);
        exp_ret(3'd2, 8'd3, 1'b0, 1'b1);
        pulse_start();
        advance(10);
        check("pause_hold_1", {bus.pc, bus.retired, bus.busy, bus.mem_we}, {3'd1, 8'd1, 1'b1, 1'b0});
        bus.step = 1'b1;
        advance(1);
        bus.step = 1'b0;
        advance(10);
        check("pause_hold_2", {bus.pc, bus.retired, bus.busy, bus.mem_we}, {3'd2, 8'd2, 1'b1, 1'b0});
        bus.step_mode = 1'b0;
        bus.step = 1'b1;
        advance(1);
        bus.step = 1'b0;
        wait_halted(20);
`endif

        advance(2);
        check("wr_queue_drained",  wr_q.size(),  0);
        check("ret_queue_drained", ret_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
